ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
Measurement-side companion to the ring oscillator tile. It enables an oscillator through `ro_en` and samples the asynchronous oscillator output `ro_in` on the system clock. It counts rising edges over a fixed gate window of clock cycles and reports a saturating count with a one-cycle valid pulse. It supports single-shot and continuous (back-to-back window) operation, plus abort.

Parameters:
- GATE_CYCLES, 1024: gate window length in clk cycles; legal range ≥ 2.
- CNT_W, 16: width of the edge counter and the result.
- SYNC_STAGES, 2: flop stages in the `ro_in` synchronizer; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all flops use its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ro_in  input  1  oscillator output, asynchronous to clk.
- start  input  1  begin a measurement; sampled only in IDLE.
- cont  input  1  continuous mode; sampled at the end of each window.
- stop  input  1  abort the current window; wins over `start` and window end.
- ro_en  output  1  oscillator enable; high whenever state is GATE.
- busy  output  1  high whenever state is GATE.
- count  output  CNT_W  last completed result; holds until the next completion.
- overflow  output  1  saturation flag belonging to `count`; updated together with it.
- valid  output  1  one-cycle pulse marking a new `count`/`overflow`.

Behaviour:
- Reset (async, any time including mid-window):
  - state = IDLE; synchronizer, edge-detect flop, timer and accumulator all cleared.
  - `count` = 0, `overflow` = 0, `valid` = 0, `ro_en` = 0, `busy` = 0.
- Synchronizer and edge detect:
  - `ro_in` passes through SYNC_STAGES flops, then one history flop.
  - `rise` = sync_out & ~hist.
  - Only correct for f_ro < f_clk/2; faster inputs alias, and this is not detected.
- FSM states: IDLE and GATE.
- IDLE:
  - If `start`=1 and `stop`=0 in cycle T: move to GATE at T+1, with timer = 0 and accumulator = 0.
  - `start` held high while in GATE is ignored.
- GATE:
  - Every cycle the timer increments.
  - On `rise`, the accumulator increments, saturating at 2^CNT_W−1.
  - An increment attempted at saturation sets the internal sat flag.
  - The gate covers exactly GATE_CYCLES cycles, T+1 .. T+GATE_CYCLES, including a rise in the last cycle.
- End of window (cycle where timer = GATE_CYCLES−1):
  - Next edge: `count` ← final accumulator value, including this cycle's rise.
  - Same edge: `overflow` ← final sat; `valid` = 1 for exactly that one cycle (T+GATE_CYCLES+1).
  - If `cont`=1 at the last gate cycle: stay in GATE. Timer, accumulator and sat restart at 0, and the first new window cycle counts its own rise, so there is no dead cycle.
  - If `cont`=0: go to IDLE. `ro_en` and `busy` drop in the same cycle that `valid` is high.
- `stop`=1 in any GATE cycle, including the last:
  - Next cycle: IDLE, no `valid`.
  - `count` and `overflow` keep their previous values; accumulator discarded.
- Timer width is clog2(GATE_CYCLES); the timer never wraps past GATE_CYCLES−1.
- The synchronizer runs in all states. Edges seen in IDLE are not counted, and the history flop is not cleared at window start.

Test Plan:
1. GATE_CYCLES=16, CNT_W=8. `ro_in` constant 0, pulse `start` at cycle 10 → `busy`/`ro_en` high cycles 11–26; `valid` at cycle 27 only; `count`=0, `overflow`=0; `busy`=0 at 27.
2. Same parameters, `ro_in` period 4 clk (2 high / 2 low), running before `start` → `count`=4, `overflow`=0. Period 2 clk (toggle every clk) → `count`=8.
3. CNT_W=3, GATE_CYCLES=16, period-2 `ro_in` → `count`=7, `overflow`=1. A following run with constant `ro_in` → `count`=0, `overflow`=0.
4. `cont`=1, period-4 `ro_in`, single `start` → `valid` at cycles 27, 43, 59; each `count`=4; `busy` stays high throughout. Drop `cont` before cycle 58 → IDLE after the 59 pulse.
5. Abort: `start` at 10, `stop` at 15 → `busy`=0 from 16; no `valid`; `count` keeps the previous result (e.g. 4). A `start`/`stop` asserted together in IDLE → stays IDLE.
6. Reset mid-window: `rst_n` low asynchronously at cycle 18 of a run → all outputs 0 immediately. After release and a new `start`, the result depends only on post-reset edges (period-4 input → 4).

Source files
------------

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: synchronizes ro_in, counts rising edges over a
// fixed gate window of clk cycles and reports a saturating result with a valid pulse.
module ro_freq_counter #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_in,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    output logic             ro_en,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid
);
    localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                 hist_reg;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [CNT_W-1:0]     acc_reg, acc_next, acc_inc;
    logic                 sat_reg, sat_next, sat_inc;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic                 overflow_reg, overflow_next;
    logic                 valid_reg, valid_next;
    logic                 rise;

    // Synchronizer and history flop run in every state; edges seen in IDLE are simply ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

    always_comb begin
        acc_inc = acc_reg;
        sat_inc = sat_reg;
        if (rise) begin
            if (acc_reg == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                acc_inc = acc_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        acc_next      = acc_reg;
        sat_next      = sat_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        valid_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = GATE;
                    timer_next = '0;
                    acc_next   = '0;
                    sat_next   = 1'b0;
                end
            end
            GATE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    // Result includes the rise of the last gate cycle; a continuing
                    // window restarts cleanly so the next cycle counts its own rise.
                    count_next    = acc_inc;
                    overflow_next = sat_inc;
                    valid_next    = 1'b1;
                    timer_next    = '0;
                    acc_next      = '0;
                    sat_next      = 1'b0;
                    if (!cont) begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                    acc_next   = acc_inc;
                    sat_next   = sat_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            acc_reg      <= '0;
            sat_reg      <= 1'b0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            acc_reg      <= acc_next;
            sat_reg      <= sat_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            valid_reg    <= valid_next;
        end
    end

    assign busy     = (state_reg == GATE);
    assign ro_en    = (state_reg == GATE);
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign valid    = valid_reg;
endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench for ro_freq_counter: two instances (8-bit and 3-bit counters) share ro_in;
// stimulus pushes expected results, a negedge monitor pops them whenever valid is seen.
module tb_ro_freq_counter;
    logic       clk;
    logic       rst_n;
    logic       ro_in;
    logic       start, start3, cont, stop;
    logic       ro_en, busy, overflow, valid;
    logic [7:0] count;
    logic       ro_en3, busy3, overflow3, valid3;
    logic [2:0] count3;

    int cyc = 0;
    int mode = 0;
    int ph = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int cnt;
        int ovf;
        int vcyc;
        int bsy;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];

    ro_freq_counter #(.GATE_CYCLES(16), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .cont(cont), .stop(stop),
        .ro_en(ro_en), .busy(busy), .count(count), .overflow(overflow), .valid(valid)
    );

    ro_freq_counter #(.GATE_CYCLES(16), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start3), .cont(1'b0), .stop(1'b0),
        .ro_en(ro_en3), .busy(busy3), .count(count3), .overflow(overflow3), .valid(valid3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator model: mode 0 constant low, 1 period 4 clk, 2 toggles every clk.
    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph = ph + 1;
            case (mode)
                1:       ro_in = ph[1];
                2:       ro_in = ph[0];
                default: ro_in = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid) begin
                if (q8.size() == 0) begin
                    check("valid8_unexpected", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("count8", int'(count), e.cnt);
                    check("overflow8", int'(overflow), e.ovf);
                    check("valid8_cycle", cyc, e.vcyc);
                    check("busy8_at_valid", int'(busy), e.bsy);
                end
            end
            if (rst_n && valid3) begin
                if (q3.size() == 0) begin
                    check("valid3_unexpected", 1, 0);
                end else begin
                    e = q3.pop_front();
                    check("count3", int'(count3), e.cnt);
                    check("overflow3", int'(overflow3), e.ovf);
                    check("valid3_cycle", cyc, e.vcyc);
                    check("busy3_at_valid", int'(busy3), e.bsy);
                end
            end
        end
    end

    task automatic measure(input int m, input int ec);
        int k;
        mode = m;
        repeat (6) tick();
        start = 1'b1;
        k = cyc;
        q8.push_back('{ec, 0, k + 17, 0});
        tick();
        start = 1'b0;
        check("busy_first_gate", int'(busy), 1);
        check("ro_en_first_gate", int'(ro_en), 1);
        repeat (15) tick();
        check("busy_last_gate", int'(busy), 1);
        repeat (4) tick();
    endtask

    task automatic measure3(input int m, input int ec, input int eo);
        int k;
        mode = m;
        repeat (6) tick();
        start3 = 1'b1;
        k = cyc;
        q3.push_back('{ec, eo, k + 17, 0});
        tick();
        start3 = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        int k;
        int all_high;
        rst_n = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        cont = 1'b0;
        stop = 1'b0;
        repeat (3) tick();
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ro_en", int'(ro_en), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Constant input, period 4, period 2
        measure(0, 0);
        measure(1, 4);
        measure(2, 8);

        // 3-bit counter saturation, then a clean run clears overflow
        measure3(2, 7, 1);
        measure3(0, 0, 0);

        // Continuous mode: three windows, cont dropped during the third
        mode = 1;
        repeat (6) tick();
        cont = 1'b1;
        start = 1'b1;
        k = cyc;
        q8.push_back('{4, 0, k + 17, 1});
        q8.push_back('{4, 0, k + 33, 1});
        q8.push_back('{4, 0, k + 49, 0});
        tick();
        start = 1'b0;
        all_high = 1;
        for (int i = 1; i <= 48; i++) begin
            if (!busy || !ro_en) all_high = 0;
            if (i == 40) cont = 1'b0;
            if (i < 48) tick();
        end
        check("busy_cont_held", all_high, 1);
        repeat (4) tick();
        check("busy_after_cont", int'(busy), 0);

        // Abort mid-window: no valid, previous result kept
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("busy_after_stop", int'(busy), 0);
        repeat (20) tick();
        check("count_kept_after_stop", int'(count), 4);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("busy_start_stop_idle", int'(busy), 0);
        repeat (3) tick();
        check("busy_start_stop_later", int'(busy), 0);

        // Asynchronous reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ro_en", int'(ro_en), 0);
        check("async_rst_overflow", int'(overflow), 0);
        check("async_rst_valid", int'(valid), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        measure(1, 4);

        repeat (5) tick();
        check("q8_drained", q8.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end
endmodule
